// File: rtl/wisc_pkg.sv
// Shared definitions for the unpipelined 16-bit WISC core: opcodes, fetch FSM
// encodings and immediate field widths.
package wisc_pkg;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;

  // All four conditional branches share this prefix; the low opcode bits pick
  // the condition, which the ALU has already folded into Zero.
  localparam logic [2:0] OP_BR_PREFIX = 3'b011;

  localparam int BR_IMM_W = 8;
  localparam int J_IMM_W  = 11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  function automatic logic [15:0] sext_br(input logic [15:0] instr);
    return {{(16-BR_IMM_W){instr[BR_IMM_W-1]}}, instr[BR_IMM_W-1:0]};
  endfunction

  function automatic logic [15:0] sext_j(input logic [15:0] instr);
    return {{(16-J_IMM_W){instr[J_IMM_W-1]}}, instr[J_IMM_W-1:0]};
  endfunction

endpackage

// File: rtl/unpipeline_next_pc.sv
// Combinational next-PC selection for the unpipelined core, resolving branches,
// PC-relative jumps and register jumps from the held instruction.
module unpipeline_next_pc
  import wisc_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [15:0] instr,
  input  logic [15:0] alu_out,
  input  logic        alu_zero,
  output logic [15:0] next_pc,
  output logic        is_halt
);

  logic [4:0]  opcode;
  logic [15:0] seq_pc;

  assign opcode = instr[15:11];
  assign seq_pc = pc + 16'd2;

  // Offsets are relative to the sequential PC; 16-bit wrap is intentional.
  always_comb begin
    next_pc = seq_pc;
    is_halt = 1'b0;
    if (opcode[4:2] == OP_BR_PREFIX) begin
      next_pc = alu_zero ? (seq_pc + sext_br(instr)) : seq_pc;
    end else if (opcode == OP_J || opcode == OP_JAL) begin
      next_pc = seq_pc + sext_j(instr);
    end else if (opcode == OP_JR || opcode == OP_JALR) begin
      next_pc = alu_out;
    end else if (opcode == OP_HALT) begin
      next_pc = pc;
      is_halt = 1'b1;
    end
  end

endmodule

// File: rtl/unpipeline_fetch_ctrl.sv
// Fetch and PC sequencing controller for the unpipelined 16-bit core.
// Define FETCH_ALIGN_CHECK_EN to trap odd next-PC values into HALTED with align_err.
module unpipeline_fetch_ctrl
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic [15:0] alu_out,
  input  logic        alu_zero,
  input  logic        retire,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        halted,
  output logic        align_err
);

  logic [1:0]  state;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic [15:0] next_pc;
  logic        is_halt;

  unpipeline_next_pc u_next_pc (
    .pc       (pc_q),
    .instr    (instr_q),
    .alu_out  (alu_out),
    .alu_zero (alu_zero),
    .next_pc  (next_pc),
    .is_halt  (is_halt)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_q;
`endif

  // A halting or faulting instruction leaves pc pointing at itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
`ifdef FETCH_ALIGN_CHECK_EN
      align_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (retire) begin
            if (is_halt) begin
              state <= ST_HALTED;
`ifdef FETCH_ALIGN_CHECK_EN
            end else if (next_pc[0]) begin
              align_q <= 1'b1;
              state   <= ST_HALTED;
`endif
            end else begin
              pc_q  <= next_pc;
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_HALTED;
      endcase
    end
  end

  assign imem_req    = (state == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state == ST_EXEC);
  assign halted      = (state == ST_HALTED);
  assign pc          = pc_q;
  assign pc_plus2    = pc_q + 16'd2;

`ifdef FETCH_ALIGN_CHECK_EN
  assign align_err = align_q;
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_unpipeline_fetch_ctrl.sv
// Directed self-checking bench for unpipeline_fetch_ctrl; inputs change and
// outputs are sampled on the falling clock edge.
module tb_unpipeline_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        retire;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        halted;
  logic        align_err;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] I_ADDI = 16'h4123;
  localparam logic [15:0] I_JR   = 16'h2800;
  localparam logic [15:0] I_JALR = 16'h3800;
  localparam logic [15:0] I_BEQZ = 16'h60FC;
  localparam logic [15:0] I_J4   = 16'h2004;
  localparam logic [15:0] I_HALT = 16'h0000;

  unpipeline_fetch_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .retire      (retire),
    .pc          (pc),
    .pc_plus2    (pc_plus2),
    .halted      (halted),
    .align_err   (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for a fetch request, checks its address, then returns the
  // word after the given number of wait states.
  task automatic applyStimulus(input string tag, input logic [15:0] exp_addr,
                               input logic [15:0] word, input int waits);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_req"}, 16'(imem_req), 16'h1);
    checkOutput({tag, "_addr"}, imem_addr, exp_addr);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      checkOutput({tag, "_wait_addr"}, imem_addr, exp_addr);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 16'hDEAD;
    checkOutput({tag, "_valid"}, 16'(instr_valid), 16'h1);
    checkOutput({tag, "_instr"}, instr, word);
    checkOutput({tag, "_req_low"}, 16'(imem_req), 16'h0);
  endtask

  task automatic retireWith(input logic [15:0] aout, input logic zero);
    alu_out  = aout;
    alu_zero = zero;
    retire   = 1'b1;
    @(negedge clk);
    retire   = 1'b0;
    alu_out  = 16'h0BAD;
    alu_zero = ~zero;
  endtask

  initial begin
    $display("[TB] starting unpipeline_fetch_ctrl bench");
    rst        = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 16'h0000;
    alu_out    = 16'h0000;
    alu_zero   = 1'b0;
    retire     = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_pc", pc, 16'h0000);
    checkOutput("rst_req", 16'(imem_req), 16'h0);
    checkOutput("rst_halted", 16'(halted), 16'h0);
    checkOutput("rst_valid", 16'(instr_valid), 16'h0);
    checkOutput("rst_instr", instr, 16'h0000);
    checkOutput("rst_align", 16'(align_err), 16'h0);

    rst = 1'b0;
    #1;
    checkOutput("idle_req", 16'(imem_req), 16'h0);
    @(negedge clk);
    checkOutput("first_req", 16'(imem_req), 16'h1);
    checkOutput("first_addr", imem_addr, 16'h0000);

    // Wait states with a stray retire that must be ignored
    retire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("wait_req", 16'(imem_req), 16'h1);
      checkOutput("wait_addr", imem_addr, 16'h0000);
    end
    retire = 1'b0;

    applyStimulus("addi", 16'h0000, I_ADDI, 0);
    imem_ready = 1'b1;
    imem_rdata = 16'hFFFF;
    @(negedge clk);
    imem_ready = 1'b0;
    checkOutput("exec_ready_ignored", instr, I_ADDI);
    checkOutput("exec_hold_valid", 16'(instr_valid), 16'h1);
    checkOutput("addi_pc_plus2", pc_plus2, 16'h0002);
    retireWith(16'hBEEF, 1'b1);

    applyStimulus("jr_to_10", 16'h0002, I_JR, 1);
    retireWith(16'h0010, 1'b0);

    applyStimulus("beqz_taken", 16'h0010, I_BEQZ, 0);
    retireWith(16'h0000, 1'b1);
    applyStimulus("jr_back", 16'h000E, I_JR, 0);
    retireWith(16'h0010, 1'b0);

    applyStimulus("beqz_not_taken", 16'h0010, I_BEQZ, 2);
    retireWith(16'h1111, 1'b0);
    applyStimulus("jr_back2", 16'h0012, I_JR, 0);
    retireWith(16'h0010, 1'b0);

    applyStimulus("jalr", 16'h0010, I_JALR, 0);
    checkOutput("jalr_pc_plus2", pc_plus2, 16'h0012);
    retireWith(16'h1234, 1'b0);

    applyStimulus("jr_to_fffe", 16'h1234, I_JR, 0);
    retireWith(16'hFFFE, 1'b0);
    applyStimulus("j_wrap", 16'hFFFE, I_J4, 0);
    checkOutput("j_wrap_pc_plus2", pc_plus2, 16'h0000);
    retireWith(16'h7777, 1'b1);

    applyStimulus("halt", 16'h0004, I_HALT, 0);
    retireWith(16'h5555, 1'b1);
    imem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("halt_halted", 16'(halted), 16'h1);
      checkOutput("halt_req", 16'(imem_req), 16'h0);
      @(negedge clk);
    end
    imem_ready = 1'b0;
    checkOutput("halt_pc", pc, 16'h0004);
    checkOutput("halt_valid", 16'(instr_valid), 16'h0);

    // Asynchronous reset between clock edges, first from HALTED then from EXEC
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_halted", 16'(halted), 16'h0);
    checkOutput("async_rst_pc", pc, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("pre_exec_rst", 16'h0000, I_ADDI, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("exec_rst_valid", 16'(instr_valid), 16'h0);
    checkOutput("exec_rst_instr", instr, 16'h0000);
    checkOutput("exec_rst_req", 16'(imem_req), 16'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("jr_odd", 16'h0000, I_JR, 0);
    retireWith(16'h1235, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      checkOutput("align_err", 16'(align_err), 16'h1);
      checkOutput("align_halted", 16'(halted), 16'h1);
      checkOutput("align_req", 16'(imem_req), 16'h0);
      checkOutput("align_pc", pc, 16'h0000);
      @(negedge clk);
    end
`else
    checkOutput("odd_align_err", 16'(align_err), 16'h0);
    checkOutput("odd_halted", 16'(halted), 16'h0);
    applyStimulus("odd_fetch", 16'h1235, I_ADDI, 0);
    checkOutput("odd_pc_plus2", pc_plus2, 16'h1237);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
